// File: rtl/stopwatch_time_core.sv
// Stopwatch time-keeping core: debounced start/clear buttons, IDLE/RUN/PAUSE control,
// 1 Hz prescaler and a BCD HH:MM:SS counter feeding the 7-segment display stage.
module stopwatch_time_core #(
    parameter int TICK_DIV        = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        clear_btn,
    output logic [23:0] time_bcd,
    output logic        running,
    output logic        tick_1hz,
    output logic [1:0]  fsm_state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   prescale;

    // Bit 0 is the start button, bit 1 the clear button.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [1:0]      press;
    logic [DW-1:0]   deb_cnt [2];

    assign btn_raw   = {clear_btn, start_btn};
    assign fsm_state = state;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            stable     <= '0;
            press      <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    // Level accepted; only a rising stable level is a press.
                    stable[i]  <= sync2[i];
                    press[i]   <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [3:0] s0, s1, m0, m1, h0, h1;
        {h1, h0, m1, m0, s1, s0} = t;
        if (s0 != 4'd9) begin
            s0 = s0 + 4'd1;
        end else begin
            s0 = 4'd0;
            if (s1 != 4'd5) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (m0 != 4'd9) begin
                    m0 = m0 + 4'd1;
                end else begin
                    m0 = 4'd0;
                    if (m1 != 4'd5) begin
                        m1 = m1 + 4'd1;
                    end else begin
                        m1 = 4'd0;
                        if (h1 == 4'd2 && h0 == 4'd3) begin
                            h1 = 4'd0;
                            h0 = 4'd0;
                        end else if (h0 != 4'd9) begin
                            h0 = h0 + 4'd1;
                        end else begin
                            h0 = 4'd0;
                            h1 = h1 + 4'd1;
                        end
                    end
                end
            end
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            running  <= 1'b0;
            tick_1hz <= 1'b0;
            prescale <= '0;
            time_bcd <= '0;
        end else begin
            tick_1hz <= 1'b0;
            case (state)
                IDLE: begin
                    prescale <= '0;
                    if (press[0]) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // The second keeps counting on the edge that pauses.
                    if (prescale == PRE_LAST) begin
                        prescale <= '0;
                        tick_1hz <= 1'b1;
                        time_bcd <= bcd_inc(time_bcd);
                    end else begin
                        prescale <= prescale + PW'(1);
                    end
                    if (press[0]) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (press[1]) begin
                        state    <= IDLE;
                        prescale <= '0;
                        time_bcd <= '0;
                    end else if (press[0]) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_time_core.sv
// Bench for stopwatch_time_core: a seconds/fraction reference model checked every cycle,
// plus a fast-prescaler instance that is run through the full 24-hour wrap.
module tb_stopwatch_time_core;

    localparam int TD   = 10;
    localparam int DEB  = 4;
    localparam int LAT  = DEB + 3;
    localparam int DEBW = 2;
    localparam int LATW = DEBW + 3;
    localparam int DAY  = 86400;

    logic        clock_100Mhz;
    logic        reset;
    logic        start_btn, clear_btn;
    logic [23:0] time_bcd;
    logic        running, tick_1hz;
    logic [1:0]  fsm_state;

    logic        start_w, clear_w;
    logic [23:0] time_w;
    logic        running_w, tick_w;
    logic [1:0]  state_w;

    stopwatch_time_core #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DEB)) u_dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .start_btn    (start_btn),
        .clear_btn    (clear_btn),
        .time_bcd     (time_bcd),
        .running      (running),
        .tick_1hz     (tick_1hz),
        .fsm_state    (fsm_state)
    );

    stopwatch_time_core #(.TICK_DIV(1), .DEBOUNCE_CYCLES(DEBW)) u_wrap (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .start_btn    (start_w),
        .clear_btn    (clear_w),
        .time_bcd     (time_w),
        .running      (running_w),
        .tick_1hz     (tick_w),
        .fsm_state    (state_w)
    );

    initial begin
        clock_100Mhz = 1'b0;
        forever #5 clock_100Mhz = ~clock_100Mhz;
    end

    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;

    int      vectors = 0;
    int      miscompares = 0;
    int      edge_n = 0;
    mstate_t m_state = M_IDLE;
    int      m_secs = 0;
    int      m_frac = 0;
    bit      m_tick = 1'b0;
    int      ev_start = -1;
    int      ev_clear = -1;
    int      start_hold = 0;
    int      clear_hold = 0;
    bit      w_run = 1'b0;
    int      w_secs = 0;
    bit      w_tick = 1'b0;
    int      ev_w = -1;
    int      w_hold = 0;

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the reference model, then compare both instances.
    task automatic cycle();
        bit se, ce;
        @(posedge clock_100Mhz);
        edge_n++;
        se = (ev_start == edge_n);
        ce = (ev_clear == edge_n);
        m_tick = 1'b0;
        if (m_state == M_RUN) begin
            m_frac++;
            if (m_frac == TD) begin
                m_frac = 0;
                m_secs = (m_secs + 1) % DAY;
                m_tick = 1'b1;
            end
        end
        case (m_state)
            M_IDLE:  if (se) m_state = M_RUN;
            M_RUN:   if (se) m_state = M_PAUSE;
            default: begin
                if (ce) begin
                    m_state = M_IDLE;
                    m_secs  = 0;
                    m_frac  = 0;
                end else if (se) begin
                    m_state = M_RUN;
                end
            end
        endcase
        w_tick = 1'b0;
        if (w_run) begin
            w_secs = (w_secs + 1) % DAY;
            w_tick = 1'b1;
        end
        if (ev_w == edge_n) w_run = 1'b1;
        #1;
        if (start_hold > 0) begin start_hold--; if (start_hold == 0) start_btn = 1'b0; end
        if (clear_hold > 0) begin clear_hold--; if (clear_hold == 0) clear_btn = 1'b0; end
        if (w_hold > 0) begin w_hold--; if (w_hold == 0) start_w = 1'b0; end
        check("running", 32'(running), 32'(m_state == M_RUN));
        check("tick_1hz", 32'(tick_1hz), 32'(m_tick));
        check("time_bcd", 32'(time_bcd), 32'(to_bcd(m_secs)));
        check("fsm_legal", 32'(fsm_state != 2'd3), 32'd1);
        check("wrap_running", 32'(running_w), 32'(w_run));
        check("wrap_tick", 32'(tick_w), 32'(w_tick));
        check("wrap_time", 32'(time_w), 32'(to_bcd(w_secs)));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) cycle();
    endtask

    // A clean press is held 10 cycles and reaches the control logic LAT edges later.
    task automatic press(input bit s, input bit c);
        if (s) begin start_btn = 1'b1; start_hold = 10; ev_start = edge_n + LAT; end
        if (c) begin clear_btn = 1'b1; clear_hold = 10; ev_clear = edge_n + LAT; end
    endtask

    initial begin
        int n, p;
        reset = 1'b1;
        start_btn = 1'b0;
        clear_btn = 1'b0;
        start_w = 1'b0;
        clear_w = 1'b0;
        #3;
        check("reset_time", 32'(time_bcd), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_tick", 32'(tick_1hz), 32'd0);
        check("reset_wrap_time", 32'(time_w), 32'd0);
        #20 reset = 1'b0;
        wait_cycles(4);

        // Glitch shorter than the debounce window.
        start_btn = 1'b1;
        start_hold = $urandom_range(1, 3);
        wait_cycles(20);
        check("glitch_no_run", 32'(running), 32'd0);

        // Clean start press.
        press(1'b1, 1'b0);
        p = edge_n;
        n = 0;
        while (running !== 1'b1 && n < 20) begin cycle(); n++; end
        check("start_rise_within_8", 32'((edge_n - p) <= 8), 32'd1);
        n = 0;
        while (m_secs != 3 && n < 100) begin cycle(); n++; end
        check("three_ticks", 32'(time_bcd), 32'h000003);

        // Pause at 00:00:05 with six cycles of the next second already counted.
        n = 0;
        while (!(m_secs == 4 && m_frac == 9) && n < 100) begin cycle(); n++; end
        press(1'b1, 1'b0);
        wait_cycles(LAT);
        check("paused_time", 32'(time_bcd), 32'h000005);
        check("paused_running", 32'(running), 32'd0);
        wait_cycles(100);
        check("pause_hold_time", 32'(time_bcd), 32'h000005);

        press(1'b1, 1'b0);
        n = 0;
        while (running !== 1'b1 && n < 20) begin cycle(); n++; end
        n = 0;
        do begin cycle(); n++; end while (tick_1hz !== 1'b1 && n < 20);
        check("resume_tick_delay", 32'(n), 32'd4);
        check("resume_time", 32'(time_bcd), 32'h000006);

        // Clear is ignored while running.
        wait_cycles($urandom_range(5, 60));
        press(1'b0, 1'b1);
        wait_cycles(20);
        check("clear_ignored_in_run", 32'(running), 32'd1);

        press(1'b1, 1'b0);
        wait_cycles(20);
        press(1'b0, 1'b1);
        wait_cycles(20);
        check("clear_in_pause_time", 32'(time_bcd), 32'd0);
        check("clear_in_pause_running", 32'(running), 32'd0);

        press(1'b0, 1'b1);
        wait_cycles(20);
        check("clear_in_idle", 32'(running), 32'd0);

        // Simultaneous start and clear in each state.
        press(1'b1, 1'b0);
        wait_cycles($urandom_range(20, 80));
        press(1'b1, 1'b0);
        wait_cycles(20);
        press(1'b1, 1'b1);
        wait_cycles(20);
        check("both_in_pause_time", 32'(time_bcd), 32'd0);
        check("both_in_pause_running", 32'(running), 32'd0);
        press(1'b1, 1'b1);
        wait_cycles(20);
        check("both_in_idle", 32'(running), 32'd1);
        wait_cycles($urandom_range(10, 60));
        press(1'b1, 1'b1);
        wait_cycles(20);
        check("both_in_run", 32'(running), 32'd0);

        // Asynchronous reset between edges while running.
        press(1'b1, 1'b0);
        wait_cycles($urandom_range(40, 90));
        #2 reset = 1'b1;
        #1;
        check("async_reset_time", 32'(time_bcd), 32'd0);
        check("async_reset_running", 32'(running), 32'd0);
        check("async_reset_tick", 32'(tick_1hz), 32'd0);
        m_state = M_IDLE; m_secs = 0; m_frac = 0; m_tick = 1'b0;
        ev_start = -1; ev_clear = -1;
        start_btn = 1'b0; clear_btn = 1'b0; start_hold = 0; clear_hold = 0;
        w_run = 1'b0; w_secs = 0; w_tick = 1'b0; ev_w = -1;
        #1 reset = 1'b0;
        wait_cycles(5);

        // Full day on the one-cycle-per-second instance.
        start_w = 1'b1;
        w_hold = 10;
        ev_w = edge_n + LATW;
        n = 0;
        while (w_secs != DAY - 1 && n < DAY + 50) begin
            cycle();
            n++;
            if (w_run && w_secs == 60) check("carry_to_minutes", 32'(time_w), 32'h000100);
            if (w_run && w_secs == 3600) check("carry_to_hours", 32'(time_w), 32'h010000);
        end
        check("reach_235959", 32'(time_w), 32'h235959);
        cycle();
        check("day_wrap_time", 32'(time_w), 32'h000000);
        check("day_wrap_running", 32'(running_w), 32'd1);
        check("day_wrap_tick", 32'(tick_w), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_time_core.md
Name: stopwatch_time_core

Overview:
- Time-keeping front end of the stopwatch. It sits directly upstream of the 7-segment time-multiplexing display.
- Debounces the start/stop and clear push-buttons and runs an IDLE/RUN/PAUSE control FSM.
- Generates the 1 Hz count enable from clock_100Mhz and drives a cascaded BCD HH:MM:SS counter.
- Presents six BCD digits that the display stage converts to segments and scans.

Parameters:
- TICK_DIV, 100000000, clock cycles per counted second (prescaler modulus).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms).

Ports:
- clock_100Mhz  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- start_btn  input  1  raw start/stop push-button, asynchronous to the clock, active-high.
- clear_btn  input  1  raw clear push-button, asynchronous to the clock, active-high.
- time_bcd  output  24  digit fields, each 4 bits, least significant field first:
  - [3:0] seconds ones
  - [7:4] seconds tens
  - [11:8] minutes ones
  - [15:12] minutes tens
  - [19:16] hours ones
  - [23:20] hours tens
- running  output  1  high while the FSM is in RUN.
- tick_1hz  output  1  one-cycle pulse on each counted second.

Behaviour:
- Clocking and reset: all state is on clock_100Mhz, with reset asynchronous and active-high.
- Reset values:
  - time_bcd = 0, running = 0, tick_1hz = 0.
  - FSM = IDLE, prescaler = 0, debounce counters = 0.
  - Debounced button levels = 0, synchronizer flops = 0.
- Button path, per button:
  - Two-flop synchronizer.
  - Debounce counter: if the synchronized level equals the stable level, the counter clears. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronized level and the counter clears.
  - A one-cycle press pulse fires on each 0->1 transition of the stable level. Releases generate nothing.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- FSM transitions, taking effect on the edge where the press pulse is high:
  - IDLE + start -> RUN.
  - RUN + start -> PAUSE.
  - PAUSE + start -> RUN.
  - PAUSE + clear -> IDLE. Counters and prescaler are zeroed on the same edge.
  - IDLE + clear -> stays in IDLE (no-op).
  - RUN + clear is ignored; clear is only honoured when stopped.
- Simultaneous start and clear pulses:
  - In IDLE: start wins, go to RUN.
  - In PAUSE: clear wins, go to IDLE.
  - In RUN: start wins, go to PAUSE.
- running = (state == RUN), registered, valid the cycle after the transition edge.
- Prescaler (width ceil(log2(TICK_DIV))):
  - In RUN it increments every cycle. At TICK_DIV-1 it wraps to 0 and tick_1hz is registered high for exactly one cycle.
  - In PAUSE it holds its value, so the sub-second fraction is preserved across pause/resume.
  - In IDLE it is held at 0.
  - The first tick after IDLE->RUN arrives exactly TICK_DIV cycles after running rises.
- BCD counter: time_bcd increments by one second on the same edge that tick_1hz is registered, so the new value and the tick pulse appear together. Carry chain:
  - sec ones 9->0 carries to sec tens.
  - sec tens 5->0 carries to min ones.
  - min ones 9->0 carries to min tens.
  - min tens 5->0 carries to hours.
  - Hours count 00..23. 23:59:59 wraps to 00:00:00, with no overflow flag.
- Each digit always holds a legal BCD value for its position: seconds/minutes tens 0-5, hours tens 0-2.
- Reset mid-count or mid-debounce clears everything immediately, regardless of clock. On deassertion the block is in IDLE showing 00:00:00.
- No combinational path from the button inputs to any output.

Test Plan:
Bench uses TICK_DIV=10 and DEBOUNCE_CYCLES=4.
- Debounce: start_btn high for 3 cycles then low -> no press pulse, running stays 0. Then start_btn held high for 20 cycles -> running rises within 2+4+2 cycles, exactly once.
- Tick timing: after running rises, tick_1hz pulses every 10 cycles. After 3 ticks, time_bcd = 0x000003.
- Pause/resume: pause at time 0x000005 with the prescaler at 6. Wait 100 cycles -> time_bcd and the prescaler are unchanged. Resume -> next tick 4 cycles after running rises, time_bcd = 0x000006.
- Carries: run from reset to 00:00:59 (tick 59) -> next tick gives 0x000100. Continue to 00:59:59 -> next tick gives 0x010000.
- Day wrap: run to 23:59:59 = 0x235959 (86399 ticks) -> next tick gives 0x000000, running stays 1.
- Clear rules:
  - clear press during RUN -> ignored.
  - clear press in PAUSE -> time_bcd = 0, IDLE.
  - Start and clear pressed in the same cycle while in PAUSE -> IDLE with time_bcd = 0.
  - Async reset pulse between clock edges while in RUN -> outputs 0 immediately.
